fpmod_iter: RTL and testbench
=============================

// Module: fpmod_iter
// PURPOSE
//  Parametrised fixed-point remainder unit: rem = a - trunc(a/b)*b, plus the fixed-point quotient.
//  Sign-magnitude Q-format operands, same format as qadd/qmult. Used by cossin_cordic for angle
//  wrapping and by other encoder blocks. No reciprocal divider: an iterative restoring core retires
//  one bit per clock. Start/done handshake; result held until the next operation.
// PARAMETERS
//  N   32  total width; bit N-1 = sign, bits N-2:0 = magnitude
//  Q   16  fractional bits; sets the quotient output scaling only
// PORTS
//  clk     in   1  clock, rising edge
//  rst     in   1  reset, asynchronous, active-low
//  start   in   1  start request; sampled in IDLE only
//  in_a    in   N  dividend a; sampled on the accepting edge
//  in_b    in   N  divisor b; sampled on the accepting edge
//  rem     out  N  remainder, sign-magnitude Q-format
//  quo     out  N  trunc(a/b) as Q-format, saturated
//  busy    out  1  high from the accepting edge through the DONE cycle
//  done    out  1  one-cycle pulse; rem/quo/flags valid from this cycle
//  dz      out  1  divide-by-zero flag for the last operation
//  ovf     out  1  quotient saturated for the last operation
// BEHAVIOUR
//  - Reset: state=IDLE. rem, quo, busy, done, dz and ovf all 0. Reset mid-operation aborts; no done.
//  - States: IDLE -> LOAD -> ITER (N-1 cycles, bit counter N-2..0) -> FIX -> DONE -> IDLE.
//  - Latency: done is high exactly N+2 edges after the edge that samples start=1 (34 for N=32).
//  - Back-to-back: start high in the DONE cycle is ignored; start is accepted only in IDLE.
//  - start while busy is ignored; inputs may change freely after acceptance.
//  - LOAD: latch sa, sb, |a|, |b|. If |b|==0 (+0 or -0), go directly to FIX with dz=1.
//  - ITER: restoring step per cycle: r = {r, |a|[k]}; if r >= |b| then r -= |b| and q[k] = 1.
//    All arithmetic is N-bit unsigned magnitude; r never exceeds |b|, so there is no overflow.
//  - Both magnitudes share the Q scaling, so the integer remainder equals the fixed-point remainder.
//  - FIX: rem = {sa, r}. Quotient sign = sa^sb. quo = {sign, q << Q}.
//    If q >= 2^(N-1-Q): quo magnitude = all ones and ovf=1.
//  - Negative zero is never output: a zero magnitude always carries sign 0 (rem and quo).
//  - dz case: rem = in_a, quo = 0, ovf = 0; latency is the same N+2 (fixed-latency simplifies callers).
//  - rem, quo, dz and ovf change only on the DONE transition and hold until the next DONE.
// CONFIGURATION
//  FPMOD_POSREM_EN defined: Euclidean result.
//    If sa=1 and r!=0: rem = +(|b| - r) and quo magnitude = q+1 (same sign/saturation rules).
//    rem is always in [0, |b|). Adjustment happens in FIX; latency is unchanged.
//  FPMOD_POSREM_EN undefined: C fmod semantics; rem takes the sign of a.
// STRUCTURE
//  - fpmod_defs.vh: state encodings (3-bit localparams), FPMOD_N_DEF=32, FPMOD_Q_DEF=16.
//  - Sub-module fpmod_divstep: combinational restoring step. Parametrised on N.
//    Inputs r_in, b, bit_in; outputs r_out, q_bit. Instantiated once and reused each ITER cycle.
//  - Top level: FSM, bit counter, operand/result registers, FIX sign/saturation logic.
// TESTING (N=32, Q=16)
//  1. a=0x00078000 (7.5), b=0x00020000 (2.0) -> rem=0x00018000, quo=0x00030000; done at edge 34.
//  2. a=0x80078000 (-7.5), b=0x00020000 -> rem=0x80018000, quo=0x80030000.
//     With FPMOD_POSREM_EN: rem=0x00008000, quo=0x80040000.
//  3. a=0x00040000, b=0x80020000 -> rem=0x00000000 (no -0), quo=0x80020000, dz=0.
//  4. b=0x80000000 (-0), a=0x12345678 -> rem=0x12345678, quo=0, dz=1; done at edge 34.
//  5. a=0x7FFF0000, b=0x00000001 -> rem=0, quo=0x7FFFFFFF, ovf=1.
//  6. start pulsed again at edge 10 of an operation -> ignored, one done only.
//     rst low at edge 20 -> all outputs 0, no done; a new start then completes normally.

Source files
------------

// File: rtl/fpmod_pkg.sv
// Shared definitions for the fpmod_iter remainder unit: default geometry and FSM state encoding.
package fpmod_pkg;

    localparam int FPMOD_N_DEF = 32;
    localparam int FPMOD_Q_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } fpmod_state_t;

endpackage

// File: rtl/fpmod_divstep.sv
// One restoring-division step on unsigned (N-1)-bit magnitudes: shift in one dividend bit,
// subtract the divisor when it fits. The partial remainder is always below b, so r_out fits.
module fpmod_divstep #(
    parameter int N = 32
) (
    input  logic [N-2:0] r_in,
    input  logic [N-2:0] b,
    input  logic         bit_in,
    output logic [N-2:0] r_out,
    output logic         q_bit
);

    logic [N-1:0] w_shift;
    logic [N-2:0] w_diff;

    // Shift-compare-subtract; the difference wraps harmlessly because it is only used when shift >= b.
    always_comb begin
        w_shift = {r_in, bit_in};
        w_diff  = w_shift[N-2:0] - b;
        if (w_shift >= {1'b0, b}) begin
            q_bit = 1'b1;
            r_out = w_diff;
        end else begin
            q_bit = 1'b0;
            r_out = w_shift[N-2:0];
        end
    end

endmodule

// File: rtl/fpmod_iter.sv
// Iterative sign-magnitude fixed-point remainder/quotient unit, one quotient bit per clock.
// Optional build macro FPMOD_POSREM_EN selects a Euclidean (non-negative) remainder.
module fpmod_iter
    import fpmod_pkg::*;
#(
    parameter int N = FPMOD_N_DEF,
    parameter int Q = FPMOD_Q_DEF      // 1 <= Q <= N-2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic [N-1:0] rem,
    output logic [N-1:0] quo,
    output logic         busy,
    output logic         done,
    output logic         dz,
    output logic         ovf
);

    localparam int MW = N - 1;
    localparam int QI = N - 1 - Q;
    localparam int BW = $clog2(N);
    localparam int CW = $clog2(N + 3);

    fpmod_state_t r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_bit;
    logic [N-1:0]  r_a_raw, r_b_raw;
    logic          r_sa, r_sb, r_dz;
    logic [MW-1:0] r_amag, r_bmag, r_r, r_q;

    logic          w_accept, w_finish, w_q_bit, w_rsign, w_sat;
    logic [MW-1:0] w_r_out, w_rmag, w_qmag;
    logic [N-1:0]  w_qext, w_rem, w_quo;

    fpmod_divstep #(.N(N)) u_step (
        .r_in   (r_r),
        .b      (r_bmag),
        .bit_in (r_amag[MW-1]),
        .r_out  (w_r_out),
        .q_bit  (w_q_bit)
    );

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_finish = (r_state == ST_FIX) && (w_next == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Next state; FIX waits on the cycle counter so the divide-by-zero path has the same latency.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_LOAD; else w_next = ST_IDLE;
            ST_LOAD: if (r_b_raw[N-2:0] == {MW{1'b0}}) w_next = ST_FIX; else w_next = ST_ITER;
            ST_ITER: if (r_bit == {BW{1'b0}}) w_next = ST_FIX; else w_next = ST_ITER;
            ST_FIX:  if (r_cnt == CW'(N + 1)) w_next = ST_DONE; else w_next = ST_FIX;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand capture, magnitude split and the restoring iteration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= {CW{1'b0}};
            r_bit   <= {BW{1'b0}};
            r_a_raw <= {N{1'b0}};
            r_b_raw <= {N{1'b0}};
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_dz    <= 1'b0;
            r_amag  <= {MW{1'b0}};
            r_bmag  <= {MW{1'b0}};
            r_r     <= {MW{1'b0}};
            r_q     <= {MW{1'b0}};
        end else begin
            if (w_accept) begin
                r_a_raw <= in_a;
                r_b_raw <= in_b;
                r_cnt   <= {CW{1'b0}};
            end else if (r_state != ST_IDLE) begin
                r_cnt <= r_cnt + CW'(1);
            end
            case (r_state)
                ST_LOAD: begin
                    r_sa   <= r_a_raw[N-1];
                    r_sb   <= r_b_raw[N-1];
                    r_amag <= r_a_raw[N-2:0];
                    r_bmag <= r_b_raw[N-2:0];
                    r_dz   <= (r_b_raw[N-2:0] == {MW{1'b0}});
                    r_r    <= {MW{1'b0}};
                    r_q    <= {MW{1'b0}};
                    r_bit  <= BW'(N - 2);
                end
                ST_ITER: begin
                    r_r    <= w_r_out;
                    r_q    <= {r_q[MW-2:0], w_q_bit};
                    r_amag <= {r_amag[MW-2:0], 1'b0};
                    r_bit  <= r_bit - BW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Sign, optional Euclidean adjustment, quotient scaling/saturation and no-negative-zero rule.
    always_comb begin
        w_rmag  = r_r;
        w_rsign = r_sa;
        w_qext  = {1'b0, r_q};
`ifdef FPMOD_POSREM_EN
        if (r_sa && (r_r != {MW{1'b0}})) begin
            w_rmag  = r_bmag - r_r;
            w_rsign = 1'b0;
            w_qext  = {1'b0, r_q} + N'(1);
        end else begin
            w_rmag  = r_r;
            w_rsign = r_sa;
            w_qext  = {1'b0, r_q};
        end
`endif
        w_sat = |w_qext[N-1:QI];
        if (w_sat) w_qmag = {MW{1'b1}};
        else       w_qmag = {w_qext[QI-1:0], {Q{1'b0}}};
        if (r_dz) begin
            w_rem = {r_a_raw[N-1] & (|r_a_raw[N-2:0]), r_a_raw[N-2:0]};
            w_quo = {N{1'b0}};
        end else begin
            w_rem = {w_rsign & (|w_rmag), w_rmag};
            w_quo = {(r_sa ^ r_sb) & (|w_qmag), w_qmag};
        end
    end

    // Registered outputs; results update only when entering DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem  <= {N{1'b0}};
            quo  <= {N{1'b0}};
            busy <= 1'b0;
            done <= 1'b0;
            dz   <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            done <= w_finish;
            if (w_accept)                 busy <= 1'b1;
            else if (r_state == ST_DONE)  busy <= 1'b0;
            if (w_finish) begin
                rem <= w_rem;
                quo <= w_quo;
                dz  <= r_dz;
                ovf <= w_sat & ~r_dz;
            end
        end
    end

endmodule

// File: tb/tb_fpmod_iter.sv
// Self-checking bench for fpmod_iter (N=32, Q=16): directed vectors, randomized operations
// against an arithmetic reference model, ignored starts, and reset abort.
module tb_fpmod_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic [31:0] rem, quo;
    logic        busy, done, dz, ovf;

    int n_checks = 0;
    int n_fail   = 0;

    fpmod_iter #(.N(32), .Q(16)) dut (
        .clk(clk), .rst(rst), .start(start), .in_a(in_a), .in_b(in_b),
        .rem(rem), .quo(quo), .busy(busy), .done(done), .dz(dz), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Reference: truncated division of magnitudes, sign rules applied afterwards.
    function automatic void ref_op(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] er, output logic [31:0] eq,
                                   output logic edz, output logic eovf);
        longint am, bm, q, r, qm;
        logic   rs;
        am = longint'(a[30:0]);
        bm = longint'(b[30:0]);
        er = 32'd0; eq = 32'd0; edz = 1'b0; eovf = 1'b0;
        if (bm == 0) begin
            edz = 1'b1;
            if (am != 0) er = a;
        end else begin
            q  = am / bm;
            r  = am % bm;
            rs = a[31];
`ifdef FPMOD_POSREM_EN
            if (a[31] && r != 0) begin
                r  = bm - r;
                q  = q + 1;
                rs = 1'b0;
            end
`endif
            if (r != 0) er = {rs, r[30:0]};
            if (q >= 64'd32768) begin
                eovf = 1'b1;
                qm   = 64'h7FFF_FFFF;
            end else begin
                qm = q * 65536;
            end
            if (qm != 0) eq = {a[31] ^ b[31], qm[30:0]};
        end
    endfunction

    // Drives one operation; optionally re-pulses start at edge pulse_edge or in the DONE cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int pulse_edge,
                          input bit start_in_done, output int lat,
                          output logic [31:0] o_rem, output logic [31:0] o_quo,
                          output logic o_dz, output logic o_ovf,
                          output logic busy_acc, output logic done_after);
        lat = -1; o_rem = 32'd0; o_quo = 32'd0; o_dz = 1'b0; o_ovf = 1'b0; done_after = 1'b0;
        @(negedge clk);
        in_a = a; in_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; busy_acc = busy;
        in_a = $urandom; in_b = $urandom;
        for (int i = 1; i <= 100; i++) begin
            if (i == pulse_edge) begin
                start = 1'b1; in_a = $urandom; in_b = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = i; o_rem = rem; o_quo = quo; o_dz = dz; o_ovf = ovf;
                if (start_in_done) begin
                    start = 1'b1; in_a = $urandom; in_b = $urandom;
                end
                @(posedge clk); #1;
                start = 1'b0;
                done_after = done;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({rem, quo, busy, done, dz, ovf} !== 68'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rem=%h quo=%h busy=%b done=%b dz=%b ovf=%b, need all 0",
                     rem, quo, busy, done, dz, ovf);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [5] = '{32'h00078000, 32'h80078000, 32'h00040000, 32'h12345678, 32'h7FFF0000};
        logic [31:0] tb [5] = '{32'h00020000, 32'h00020000, 32'h80020000, 32'h80000000, 32'h00000001};
        logic [31:0] tr [5] = '{32'h00018000, 32'h80018000, 32'h00000000, 32'h12345678, 32'h00000000};
        logic [31:0] tq [5] = '{32'h00030000, 32'h80030000, 32'h80020000, 32'h00000000, 32'h7FFFFFFF};
        logic        tz [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        to [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat; logic [31:0] r, q; logic z, o, ba, da;
`ifdef FPMOD_POSREM_EN
        tr[1] = 32'h00008000;
        tq[1] = 32'h80040000;
`endif
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], 0, 1'b0, lat, r, q, z, o, ba, da);
            n_checks++;
            if (lat !== 34) begin
                n_fail++; $display("FAIL dir%0d_latency: got %0d need 34", i + 1, lat);
            end
            n_checks++;
            if (r !== tr[i] || q !== tq[i]) begin
                n_fail++; $display("FAIL dir%0d_result: got rem=%h quo=%h need rem=%h quo=%h",
                                   i + 1, r, q, tr[i], tq[i]);
            end
            n_checks++;
            if (z !== tz[i] || o !== to[i]) begin
                n_fail++; $display("FAIL dir%0d_flags: got dz=%b ovf=%b need dz=%b ovf=%b",
                                   i + 1, z, o, tz[i], to[i]);
            end
            n_checks++;
            if (ba !== 1'b1 || da !== 1'b0) begin
                n_fail++; $display("FAIL dir%0d_handshake: got busy_at_accept=%b done_next=%b need 1/0",
                                   i + 1, ba, da);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, er, eq, r, q;
        logic [30:0] m;
        logic edz, eovf, z, o, ba, da;
        int lat;
        for (int i = 0; i < 30; i++) begin
            m = 31'($urandom);
            a = {1'($urandom), m >> $urandom_range(0, 20)};
            m = 31'($urandom);
            case ($urandom_range(0, 9))
                0:       b = {1'($urandom), 31'd0};
                1:       b = {1'($urandom), 31'($urandom_range(1, 3))};
                default: b = {1'($urandom), m >> $urandom_range(0, 30)};
            endcase
            ref_op(a, b, er, eq, edz, eovf);
            run_op(a, b, 0, 1'b0, lat, r, q, z, o, ba, da);
            n_checks++;
            if (lat !== 34 || r !== er || q !== eq || z !== edz || o !== eovf) begin
                n_fail++;
                $display("FAIL rand%0d: a=%h b=%h got lat=%0d rem=%h quo=%h dz=%b ovf=%b need lat=34 rem=%h quo=%h dz=%b ovf=%b",
                         i, a, b, lat, r, q, z, o, er, eq, edz, eovf);
            end
            n_checks++;
            if (rem !== er || quo !== eq) begin
                n_fail++; $display("FAIL rand%0d_hold: got rem=%h quo=%h need rem=%h quo=%h", i, rem, quo, er, eq);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int lat, extra;
        logic [31:0] r, q; logic z, o, ba, da;
        run_op(32'h00078000, 32'h00020000, 10, 1'b0, lat, r, q, z, o, ba, da);
        n_checks++;
        if (lat !== 34 || r !== 32'h00018000 || q !== 32'h00030000) begin
            n_fail++; $display("FAIL busy_start_result: got lat=%0d rem=%h quo=%h need 34/00018000/00030000", lat, r, q);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        n_checks++;
        if (extra !== 0 || da !== 1'b0) begin
            n_fail++; $display("FAIL busy_start_extra_done: got %0d extra pulses need 0", extra + int'(da));
        end
    endtask

    task automatic test_back_to_back();
        int lat, extra, busy_seen;
        logic [31:0] r, q; logic z, o, ba, da;
        run_op(32'h00040000, 32'h80020000, 0, 1'b1, lat, r, q, z, o, ba, da);
        n_checks++;
        if (lat !== 34 || r !== 32'h00000000 || q !== 32'h80020000) begin
            n_fail++; $display("FAIL b2b_result: got lat=%0d rem=%h quo=%h need 34/00000000/80020000", lat, r, q);
        end
        extra = 0; busy_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra++;
            if (busy) busy_seen++;
        end
        n_checks++;
        if (extra !== 0 || busy_seen !== 0 || da !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ignored: got done=%0d busy_cycles=%0d need 0/0", extra + int'(da), busy_seen);
        end
    endtask

    task automatic test_reset_abort();
        int lat, extra;
        logic [31:0] r, q; logic z, o, ba, da;
        @(negedge clk);
        in_a = 32'h80078000; in_b = 32'h00020000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({rem, quo, busy, done, dz, ovf} !== 68'd0) begin
            n_fail++;
            $display("FAIL abort_outputs: got rem=%h quo=%h busy=%b done=%b dz=%b ovf=%b, need all 0",
                     rem, quo, busy, done, dz, ovf);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        extra = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++; $display("FAIL abort_no_done: got %0d active cycles need 0", extra);
        end
        run_op(32'h00078000, 32'h00020000, 0, 1'b0, lat, r, q, z, o, ba, da);
        n_checks++;
        if (lat !== 34 || r !== 32'h00018000 || q !== 32'h00030000 || z !== 1'b0 || o !== 1'b0) begin
            n_fail++; $display("FAIL abort_recover: got lat=%0d rem=%h quo=%h dz=%b ovf=%b need 34/00018000/00030000/0/0",
                               lat, r, q, z, o);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_start_while_busy();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
